// File: rtl/keccak_obi_pkg.sv
// Shared types and constants for the Keccak OBI state-buffer slave.
// Address map, FSM encoding and OBI request/response bundles.
package keccak_obi_pkg;

   localparam int STATE_WORDS = 50;
   localparam int STATE_BITS  = STATE_WORDS * 32;

   localparam logic [31:0] STATE_END   = 32'(STATE_WORDS * 4);
   localparam logic [31:0] CTRL_OFFS   = 32'h0000_00C8;
   localparam logic [31:0] STATUS_OFFS = 32'h0000_00CC;
   localparam logic [31:0] IE_OFFS     = 32'h0000_00D0;

   localparam int START_BIT = 0;
   localparam int BUSY_BIT  = 0;
   localparam int DONE_BIT  = 1;
   localparam int IE_BIT    = 0;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } keccak_slv_state_e;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;

endpackage

// File: rtl/keccak_obi_slave.sv
// OBI slave holding a 1600-bit Keccak state and CTRL/STATUS/IE registers.
// Define KECCAK_OBI_BUSY_STALL_EN to stall STATE accesses while busy.
module keccak_obi_slave
   import keccak_obi_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  obi_req_t              slave_req_i,
   output obi_resp_t             slave_resp_o,
   output logic                  keccak_start_o,
   output logic [STATE_BITS-1:0] keccak_state_o,
   input  logic                  keccak_done_i,
   input  logic [STATE_BITS-1:0] keccak_state_i,
   output logic                  keccak_int_o
);

   localparam int WIDX_W = ADDR_WIDTH - 2;

   keccak_slv_state_e state_q, state_d;

   logic [STATE_BITS-1:0] buf_q;
   logic                  ie_q;
   logic                  done_q;
   logic                  start_q;
   logic                  rvalid_q;
   logic [31:0]           rdata_q;

   logic [ADDR_WIDTH-1:0] offs;
   logic [WIDX_W-1:0]     widx;
   logic [31:0]           offs32;
   logic                  sel_state;
   logic                  sel_ctrl;
   logic                  sel_status;
   logic                  sel_ie;
   logic                  busy;
   logic                  gnt;
   logic                  acc;
   logic                  wr;
   logic                  rd;
   logic                  start_req;
   logic                  clr_done;
   logic                  capture;
   logic                  start_fire;
   logic [31:0]           rd_word;
   logic                  unused_addr;

   // Decode the byte offset; the low two address bits never matter.
   assign offs   = slave_req_i.addr[ADDR_WIDTH-1:0];
   assign widx   = offs[ADDR_WIDTH-1:2];
   assign offs32 = 32'({widx, 2'b00});

   assign unused_addr = ^slave_req_i.addr;

   assign sel_state  = offs32 < STATE_END;
   assign sel_ctrl   = offs32 == CTRL_OFFS;
   assign sel_status = offs32 == STATUS_OFFS;
   assign sel_ie     = offs32 == IE_OFFS;

   assign busy = state_q == RUN;

`ifdef KECCAK_OBI_BUSY_STALL_EN
   assign gnt = slave_req_i.req & ~(sel_state & busy);
`else
   assign gnt = slave_req_i.req;
`endif

   assign acc = slave_req_i.req & gnt;
   assign wr  = acc & slave_req_i.we;
   assign rd  = acc & ~slave_req_i.we;

   assign start_req = wr & sel_ctrl & slave_req_i.be[0]
                    & slave_req_i.wdata[START_BIT];
   assign clr_done  = wr & sel_status & slave_req_i.be[0]
                    & slave_req_i.wdata[DONE_BIT];

   // Next-state logic for the one-shot permutation handshake.
   always_comb begin
      state_d    = state_q;
      start_fire = 1'b0;
      capture    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_req) begin
               start_fire = 1'b1;
               state_d    = RUN;
            end
         end
         RUN: begin
            if (keccak_done_i) begin
               capture = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Read data mux over the address map.
   always_comb begin
      rd_word = '0;
      unique case (1'b1)
         sel_state: begin
            for (int i = 0; i < STATE_WORDS; i++) begin
               if (widx == WIDX_W'(i)) rd_word = buf_q[32*i +: 32];
            end
         end
         sel_status: begin
            rd_word[BUSY_BIT] = busy;
            rd_word[DONE_BIT] = done_q;
         end
         sel_ie: rd_word[IE_BIT] = ie_q;
         default: rd_word = '0;
      endcase
   end

   // State buffer: capture beats a concurrent bus write; busy drops writes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         buf_q <= '0;
      end else if (capture) begin
         buf_q <= keccak_state_i;
      end else if (wr && sel_state && !busy) begin
         for (int i = 0; i < STATE_WORDS; i++) begin
            for (int b = 0; b < 4; b++) begin
               if (widx == WIDX_W'(i) && slave_req_i.be[b])
                  buf_q[32*i+8*b +: 8] <= slave_req_i.wdata[8*b +: 8];
            end
         end
      end
   end

   // Sticky DONE flag; a core completion beats a same-cycle clear.
   always_ff @(posedge clk_i) begin
      if (rst_i)         done_q <= 1'b0;
      else if (capture)  done_q <= 1'b1;
      else if (clr_done) done_q <= 1'b0;
   end

   // Interrupt enable register.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         ie_q <= 1'b0;
      else if (wr && sel_ie && slave_req_i.be[0])
         ie_q <= slave_req_i.wdata[IE_BIT];
   end

   // One-cycle start pulse launched the cycle after the CTRL write.
   always_ff @(posedge clk_i) begin
      if (rst_i) start_q <= 1'b0;
      else       start_q <= start_fire;
   end

   // Response channel: one rvalid per granted request, rdata 0 on writes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= acc;
         rdata_q  <= rd ? rd_word : 32'h0;
      end
   end

   assign slave_resp_o.gnt    = gnt;
   assign slave_resp_o.rvalid = rvalid_q;
   assign slave_resp_o.rdata  = rdata_q;

   assign keccak_start_o = start_q;
   assign keccak_state_o = buf_q;
   assign keccak_int_o   = done_q & ie_q;

endmodule
